// File: rtl/fixed_point_add_arbiter.sv
// -----------------------------------------------------------------------------
// fixed_point_add_arbiter
//
// Four requesters share one combinational sign-magnitude adder. A round-robin
// arbiter picks one pending request per slot. The slot is a three-state FSM:
// IDLE (arbitrate and latch operands), ADD (grant pulse), OUT (result pulse).
// One add completes every three cycles.
//
// Handshake: a requester raises req[i] and holds its op_a/op_b slices stable
// until it sees grant[i] high for one cycle. Once grant[i] has been seen, the
// operands are captured and req[i] may drop. result/result_id/overflow are
// valid in the single cycle where result_valid is high. result and result_id
// keep their values until the next result.
//
// Ports
//   clk           system clock, rising edge
//   n_rst         synchronous active-low reset
//   req[3:0]      per-requester request
//   op_a[127:0]   operand A, requester i on [32i+31:32i], sign-magnitude
//   op_b[127:0]   operand B, same packing
//   grant[3:0]    one-hot grant, high in the ADD cycle only
//   result[31:0]  sign-magnitude sum
//   result_valid  one-cycle pulse in the OUT cycle
//   result_id     index of the requester owning result
//   overflow      magnitude carry out of bit 30, valid with result_valid
//   busy          FSM is not in IDLE
//   o_state       FSM state for debug (0 IDLE, 1 ADD, 2 OUT)
// -----------------------------------------------------------------------------

// Combinational sign-magnitude adder (bit 31 sign, bits 30:0 magnitude).
// Unlike signs with equal magnitudes give magnitude 0 carrying the sign of i_a.
module fixed_point_add (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum,
    output logic        o_overflow
);
    logic        w_sa;
    logic        w_sb;
    logic [30:0] w_ma;
    logic [30:0] w_mb;
    logic [31:0] w_add;

    assign w_sa  = i_a[31];
    assign w_sb  = i_b[31];
    assign w_ma  = i_a[30:0];
    assign w_mb  = i_b[30:0];
    assign w_add = {1'b0, w_ma} + {1'b0, w_mb};

    always_comb begin
        o_sum      = '0;
        o_overflow = 1'b0;
        if (w_sa == w_sb) begin
            // Carry out of the magnitude is flagged and the magnitude wraps.
            o_sum      = {w_sa, w_add[30:0]};
            o_overflow = w_add[31];
        end else if (w_ma >= w_mb) begin
            // ">=" makes the equal-magnitude case take the sign of i_a.
            o_sum = {w_sa, w_ma - w_mb};
        end else begin
            o_sum = {w_sb, w_mb - w_ma};
        end
    end
endmodule

module fixed_point_add_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  op_a,
    input  logic [32*NUM_REQ-1:0]  op_b,
    output logic [NUM_REQ-1:0]     grant,
    output logic [31:0]            result,
    output logic                   result_valid,
    output logic [1:0]             result_id,
    output logic                   overflow,
    output logic                   busy,
    output logic [1:0]             o_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [NUM_REQ-1:0]   r_grant;
    logic [31:0]          r_result;
    logic                 r_result_valid;
    logic [1:0]           r_result_id;
    logic                 r_overflow;
    logic [1:0]           r_last_id;
    logic [31:0]          r_op_a;
    logic [31:0]          r_op_b;

    logic [1:0]           w_idx;
    logic [1:0]           w_winner;
    logic                 w_found;
    logic [31:0]          w_sum;
    logic                 w_sum_ovf;

    // The adder sees only the captured operands, so requesters may drop
    // their buses as soon as they are granted.
    fixed_point_add u_add (
        .i_a        (r_op_a),
        .i_b        (r_op_b),
        .o_sum      (w_sum),
        .o_overflow (w_sum_ovf)
    );

    // Round-robin search: start one past the last winner and wrap.
    always_comb begin
        w_idx    = '0;
        w_found  = 1'b0;
        w_winner = r_last_id;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = r_last_id + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (|req) w_next_state = S_ADD;
            S_ADD:   w_next_state = S_OUT;
            S_OUT:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_grant        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_result_id    <= '0;
            r_overflow     <= 1'b0;
            r_last_id      <= 2'd3;   // first search after reset starts at 0
            r_op_a         <= '0;
            r_op_b         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_grant        <= '0;
                    r_result_valid <= 1'b0;
                    r_overflow     <= 1'b0;
                    if (|req) begin
                        r_op_a      <= op_a[32*w_winner +: 32];
                        r_op_b      <= op_b[32*w_winner +: 32];
                        r_grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
                        r_last_id   <= w_winner;
                        r_result_id <= w_winner;
                    end
                end
                S_ADD: begin
                    r_grant        <= '0;
                    r_result       <= w_sum;
                    r_overflow     <= w_sum_ovf;
                    r_result_valid <= 1'b1;
                end
                S_OUT: begin
                    r_result_valid <= 1'b0;
                    r_overflow     <= 1'b0;
                end
                default: begin
                    r_grant        <= '0;
                    r_result_valid <= 1'b0;
                    r_overflow     <= 1'b0;
                end
            endcase
        end
    end

    assign grant        = r_grant;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign result_id    = r_result_id;
    assign overflow     = r_overflow;
    assign busy         = (r_state != S_IDLE);
    assign o_state      = r_state;
endmodule

// File: doc/fixed_point_add_arbiter.md
FIXED_POINT_ADD_ARBITER -- requirements
Module: fixed_point_add_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning number of requesters sharing one adder; fixed at 4 for this release.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 n_rst  input  1  reset, synchronous and active-low; the block has one clock only.
REQ-004 req  input  4  per-requester request; bit i held high with operands stable until grant[i] is seen.
REQ-005 op_a  input  128  operand A bus, requester i on bits [32i+31:32i], sign-magnitude (bit31 sign, bits30:0 magnitude).
REQ-006 op_b  input  128  operand B bus, same packing and format as op_a.
REQ-007 grant  output  4  registered one-hot grant, high exactly one cycle per accepted request.
REQ-008 result  output  32  registered sign-magnitude sum, held until next result.
REQ-009 result_valid  output  1  registered one-cycle pulse marking result/result_id/overflow valid.
REQ-010 result_id  output  2  index of requester that owns the current result.
REQ-011 overflow  output  1  high with result_valid when the magnitude sum exceeded 31 bits.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The block SHALL contain one instance of the team's combinational fixed_point_add, fed only from internal operand registers.
REQ-014 FSM states SHALL be IDLE, ADD, OUT; IDLE->ADD on a rising edge with req!=0, ADD->OUT unconditionally, OUT->IDLE unconditionally.
REQ-015 In IDLE with req==0 the FSM SHALL remain in IDLE and all registered outputs SHALL hold (result, result_id) or be 0 (grant, result_valid, overflow).
REQ-016 Winner selection SHALL be round-robin: search starts at (last_id+1) mod 4 and increments mod 4; first set req bit wins.
REQ-017 On IDLE->ADD the block SHALL latch the winner's op_a/op_b slices, set grant to onehot(winner), set last_id and result_id to winner.
REQ-018 grant SHALL be high only during the ADD cycle and SHALL be 0 in IDLE and OUT.
REQ-019 On ADD->OUT the block SHALL register the adder output into result, set overflow, and set result_valid to 1 for the OUT cycle only.
REQ-020 Latency: request sampled at edge E0 -> grant high E0..E1 -> result_valid high E1..E2; FSM in IDLE again at E2; throughput one add per 3 cycles.
REQ-021 Arithmetic: same signs -> magnitudes added, sign kept; different signs -> larger magnitude minus smaller, sign of larger.
REQ-022 Equal magnitudes with different signs SHALL yield magnitude 0 with the sign of op_a (e.g. 0x80000001 + 0x00000001 = 0x80000000).
REQ-023 Same-sign magnitude carry out of bit30 SHALL set overflow=1 and result magnitude SHALL be the low 31 bits (wrap).
REQ-024 Requests changing during ADD or OUT SHALL be ignored; a req bit still high at the IDLE edge after OUT SHALL be treated as a new request.
REQ-025 A requester deasserting req before its grant SHALL lose the request with no side effect.

Reset
REQ-026 On a rising edge with n_rst=0 the block SHALL enter IDLE, clear grant, result, result_valid, result_id, overflow, busy to 0, and set last_id to 3.
REQ-027 Reset during ADD or OUT SHALL abort the operation with no result_valid pulse generated for it.
REQ-028 After reset the first arbitration SHALL favour requester 0.

Verification
REQ-029 Single request: req=0001, op_a[0]=0x00000001, op_b[0]=0x00000001 -> grant=0001 one cycle, next cycle result=0x00000002, result_id=0, overflow=0, result_valid pulse.
REQ-030 Sign cases via requester 2: (0x80000002,0x00000001)->0x80000001; (0x00000001,0x80000002)->0x80000001; (0x80000001,0x80000001)->0x80000002; (0x00000002,0x80000001)->0x00000001.
REQ-031 Round-robin: req=1111 held continuously after reset, each requester dropping its bit after its grant -> grant order 0,1,2,3 with result_id matching.
REQ-032 Fairness: req=1001 held permanently -> grants alternate 0,3,0,3 on successive 3-cycle slots.
REQ-033 Overflow: op_a=0x7FFFFFFF, op_b=0x00000001 -> result=0x00000000, overflow=1.
REQ-034 Reset mid-op: assert n_rst=0 in ADD cycle -> no result_valid, all outputs 0, next req=1000 granted as grant=1000 with result_id=3.
